memory_responder: RTL and testbench
===================================

MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 The block SHALL have parameter MEM_WORDS, default 1024, giving RAM depth in 32-bit words (power of two).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, giving console FIFO entries (power of two, >=2).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 resetn  input  1  reset, synchronous and active-low, sampled on the rising edge of clk.
REQ-005 address  input  32  byte address from the core.
REQ-006 data_in  input  32  write data from the core.
REQ-007 we  input  1  write enable from the core; 1 = write this cycle.
REQ-008 data_out  output  32  registered read data to the core.
REQ-009 console_data  output  8  byte at the console FIFO head.
REQ-010 console_valid  output  1  FIFO non-empty; console_data is valid.
REQ-011 console_ready  input  1  sink accepts the head byte when console_valid=1 on the same edge.

Function
REQ-012 Address map SHALL be: RAM 0x0000_0000 to 4*MEM_WORDS-1; CONSOLE_TX 0xFFFF_FF00; CONSOLE_STATUS 0xFFFF_FF04; CYCLE_COUNT 0xFFFF_FF08; everything else unmapped.
REQ-013 RAM word index SHALL be address[log2(MEM_WORDS)+1:2]; address[1:0] ignored; no byte enables.
REQ-014 Read latency SHALL be one cycle: data_out at edge N+1 reflects the address presented before edge N+1, every cycle, regardless of we.
REQ-015 RAM read and write to the same word on the same edge SHALL return the old word (read-before-write).
REQ-016 Unmapped reads SHALL return 0x0000_0000; unmapped writes SHALL have no effect.
REQ-017 Write to CONSOLE_TX SHALL push data_in[7:0] into the FIFO; a push when full with no pop on that edge SHALL drop the byte and set sticky overflow.
REQ-018 Pop SHALL occur on an edge with console_valid=1 and console_ready=1; console_ready with an empty FIFO SHALL do nothing.
REQ-019 Simultaneous push and pop when full SHALL accept the push, keep count unchanged, and not set overflow.
REQ-020 Simultaneous push and pop when empty SHALL not occur (no bypass); the pushed byte appears on console_data one cycle later with console_valid=1.
REQ-021 FIFO pointers SHALL wrap modulo FIFO_DEPTH; bytes SHALL leave in push order.
REQ-022 CONSOLE_STATUS read SHALL return bit0 empty, bit1 full, bit2 overflow, bits[15:8] entry count, other bits 0; any write to CONSOLE_STATUS SHALL clear overflow.
REQ-023 Overflow set and clear on the same edge SHALL resolve to set.
REQ-024 Cycle counter SHALL increment by 1 every edge outside reset, wrapping 0xFFFF_FFFF to 0.
REQ-025 Write to CYCLE_COUNT SHALL load data_in; the counter SHALL read data_in+1 one edge later.
REQ-026 CYCLE_COUNT and CONSOLE_STATUS reads SHALL return the value held just before the sampling edge.

Reset
REQ-027 On an edge with resetn=0: data_out=0, FIFO empty (console_valid=0, console_data=0), overflow=0, cycle counter=0; we and console_ready ignored.
REQ-028 RAM contents SHALL NOT be cleared by reset.
REQ-029 Reset mid-operation SHALL discard all FIFO contents and any write presented on that edge.

Configuration
REQ-030 With MEMORY_RESPONDER_CONSOLE_EN defined, the console FIFO and CONSOLE_TX/CONSOLE_STATUS registers SHALL exist as specified.
REQ-031 Without MEMORY_RESPONDER_CONSOLE_EN, CONSOLE_TX and CONSOLE_STATUS SHALL behave as unmapped, console_valid=0 and console_data=0 constantly, console_ready ignored; RAM and cycle counter unchanged.

Verification
REQ-032 Write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0012 -> data_out=0xDEADBEEF one cycle after the read address.
REQ-033 Same-edge write 0x1 and read of word 0x20 holding 0x5 -> data_out=0x5; next read -> 0x1.
REQ-034 console_ready=0, push 0x41,0x42,0x43,0x44,0x45 -> status reads 0x0000_0406 (full, overflow, count 4); release ready -> 0x41..0x44 in order, then console_valid=0.
REQ-035 FIFO full, push 0x55 with console_ready=1 on the same edge -> count stays 4, overflow stays 0, 0x55 emerges last.
REQ-036 Write 0xFFFF_FFFE to CYCLE_COUNT, read on following edges -> 0xFFFF_FFFF, 0x0000_0000.
REQ-037 Hold resetn=0 one edge with 3 bytes queued -> console_valid=0, status reads 0x0000_0001, RAM word previously written unchanged.

Source files
------------

// File: rtl/memory_responder.sv
// memory_responder: word RAM, free-running cycle counter and an optional console TX FIFO on a simple core bus.
// Define MEMORY_RESPONDER_CONSOLE_EN to build the console FIFO and its CONSOLE_TX/CONSOLE_STATUS registers.
module memory_responder #(
    parameter int MEM_WORDS  = 1024,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    input  logic        we,
    output logic [31:0] data_out,
    output logic [7:0]  console_data,
    output logic        console_valid,
    input  logic        console_ready
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam logic [31:0] ADDR_TX     = 32'hFFFF_FF00;
    localparam logic [31:0] ADDR_STATUS = 32'hFFFF_FF04;
    localparam logic [31:0] ADDR_CYCLE  = 32'hFFFF_FF08;

    logic [31:0]   ram_q [MEM_WORDS];
    logic [31:0]   data_out_q, data_out_d;
    logic [31:0]   cycle_q, cycle_d;
    logic          ram_hit;
    logic [AW-1:0] ram_idx;
    logic [31:0]   console_rd;

    assign ram_hit  = (address[31:AW+2] == '0);
    assign ram_idx  = address[AW+1:2];
    assign data_out = data_out_q;

    // Reads sample state from before the edge, so a same-edge RAM write returns the old word.
    always_comb begin
        data_out_d = '0;
        if (ram_hit) begin
            data_out_d = ram_q[ram_idx];
        end else if (address == ADDR_CYCLE) begin
            data_out_d = cycle_q;
        end else begin
            data_out_d = console_rd;
        end
        cycle_d = (we && (address == ADDR_CYCLE)) ? data_in : cycle_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            data_out_q <= '0;
            cycle_q    <= '0;
        end else begin
            data_out_q <= data_out_d;
            cycle_q    <= cycle_d;
        end
    end

    // RAM is never cleared; a write presented on a reset edge is dropped.
    always_ff @(posedge clk) begin
        if (resetn && we && ram_hit) begin
            ram_q[ram_idx] <= data_in;
        end
    end

`ifdef MEMORY_RESPONDER_CONSOLE_EN
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    logic [7:0]    fifo_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          push_req, push_ok, pop, empty, full, status_clr;

    // A full FIFO still takes a push when the head leaves on the same edge; there is no empty bypass.
    always_comb begin
        empty      = (count_q == '0);
        full       = (count_q == FULL_COUNT);
        push_req   = we && (address == ADDR_TX);
        status_clr = we && (address == ADDR_STATUS);
        pop        = !empty && console_ready;
        push_ok    = push_req && (!full || pop);
        wr_ptr_d   = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d    = count_q + CW'(push_ok) - CW'(pop);
        overflow_d = overflow_q;
        if (push_req && full && !pop) begin
            overflow_d = 1'b1;
        end else if (status_clr) begin
            overflow_d = 1'b0;
        end
        console_rd = '0;
        if (address == ADDR_STATUS) begin
            console_rd = {16'h0, 8'(count_q), 5'h0, overflow_q, full, empty};
        end
        console_valid = !empty;
        console_data  = empty ? 8'h00 : fifo_q[rd_ptr_q];
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn && push_ok) begin
            fifo_q[wr_ptr_q] <= data_in[7:0];
        end
    end
`else
    logic unused_console;

    assign unused_console = console_ready ^ FIFO_DEPTH[0];
    assign console_rd     = '0;
    assign console_valid  = 1'b0;
    assign console_data   = 8'h00;
`endif

endmodule

// File: tb/tb_memory_responder.sv
// Self-checking bench for memory_responder: directed vector table, console corner sequences,
// and randomized traffic checked against a queue/array reference model.
module tb_memory_responder;
    localparam int MEM_WORDS  = 1024;
    localparam int FIFO_DEPTH = 4;
    localparam logic [31:0] RAM_BYTES = 32'(4 * MEM_WORDS);
    localparam logic [31:0] A_TX  = 32'hFFFF_FF00;
    localparam logic [31:0] A_ST  = 32'hFFFF_FF04;
    localparam logic [31:0] A_CYC = 32'hFFFF_FF08;
    localparam logic [31:0] A_NUL = 32'h8000_0000;
`ifdef MEMORY_RESPONDER_CONSOLE_EN
    localparam bit CONSOLE_EN = 1'b1;
`else
    localparam bit CONSOLE_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] address;
    logic [31:0] data_in;
    logic        we;
    logic [31:0] data_out;
    logic [7:0]  console_data;
    logic        console_valid;
    logic        console_ready;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] ram_m [int];
    logic [31:0] cyc_m;
    logic [7:0]  fifo_m [$];
    bit          ovf_m;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] din;
        logic        w;
        bit          chk;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [$];

    memory_responder #(
        .MEM_WORDS (MEM_WORDS),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .address      (address),
        .data_in      (data_in),
        .we           (we),
        .data_out     (data_out),
        .console_data (console_data),
        .console_valid(console_valid),
        .console_ready(console_ready)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One bus cycle: predict the read from pre-edge model state, clock, then advance the model.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] din, input logic w,
                                 input logic rdy, input logic rst_n);
        logic [31:0] exp_dout;
        bit          known;
        bit          pop;
        address       = addr;
        data_in       = din;
        we            = w;
        console_ready = rdy;
        resetn        = rst_n;
        known    = 1'b1;
        exp_dout = 32'h0;
        if (!rst_n) begin
            exp_dout = 32'h0;
        end else if (addr < RAM_BYTES) begin
            if (ram_m.exists(int'(addr >> 2))) exp_dout = ram_m[int'(addr >> 2)];
            else known = 1'b0;
        end else if (addr == A_CYC) begin
            exp_dout = cyc_m;
        end else if (CONSOLE_EN && addr == A_ST) begin
            exp_dout = {16'h0, 8'(fifo_m.size()), 5'h0, ovf_m,
                        fifo_m.size() == FIFO_DEPTH, fifo_m.size() == 0};
        end
        @(posedge clk);
        #1;
        if (!rst_n) begin
            cyc_m = 32'h0;
            fifo_m.delete();
            ovf_m = 1'b0;
        end else begin
            if (w && addr < RAM_BYTES) ram_m[int'(addr >> 2)] = din;
            cyc_m = (w && addr == A_CYC) ? din : cyc_m + 32'd1;
            if (CONSOLE_EN) begin
                pop = (fifo_m.size() > 0) && rdy;
                if (pop) void'(fifo_m.pop_front());
                if (w && addr == A_TX) begin
                    if (fifo_m.size() < FIFO_DEPTH) fifo_m.push_back(din[7:0]);
                    else ovf_m = 1'b1;
                end else if (w && addr == A_ST) begin
                    ovf_m = 1'b0;
                end
            end
        end
        if (known) checkOutput("data_out", data_out, exp_dout);
        checkOutput("console_valid", 32'(console_valid), 32'(fifo_m.size() > 0));
        if (fifo_m.size() > 0) checkOutput("console_data", 32'(console_data), 32'(fifo_m[0]));
        else if (!rst_n) checkOutput("console_data_rst", 32'(console_data), 32'h0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic        w;
        logic        r;
        logic        rn;
        int          sel;

        vecs.push_back('{32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0});
        vecs.push_back('{32'h0000_0012, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF});
        vecs.push_back('{32'h0000_0080, 32'h5,         1'b1, 1'b0, 32'h0});
        vecs.push_back('{32'h0000_0080, 32'h1,         1'b1, 1'b1, 32'h5});
        vecs.push_back('{32'h0000_0080, 32'h0,         1'b0, 1'b1, 32'h1});
        vecs.push_back('{32'h0000_0013, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF});
        vecs.push_back('{32'h0000_0000, 32'h1111_2222, 1'b1, 1'b0, 32'h0});
        vecs.push_back('{32'h0000_1000, 32'h0000_CAFE, 1'b1, 1'b1, 32'h0});
        vecs.push_back('{32'h0000_1000, 32'h0,         1'b0, 1'b1, 32'h0});
        vecs.push_back('{32'h0000_0000, 32'h0,         1'b0, 1'b1, 32'h1111_2222});
        vecs.push_back('{32'h0000_0FFC, 32'hA5A5_5A5A, 1'b1, 1'b0, 32'h0});
        vecs.push_back('{32'h0000_0FFF, 32'h0,         1'b0, 1'b1, 32'hA5A5_5A5A});
        vecs.push_back('{A_NUL,         32'h0,         1'b0, 1'b1, 32'h0});
        vecs.push_back('{A_CYC,         32'hFFFF_FFFE, 1'b1, 1'b0, 32'h0});
        vecs.push_back('{A_CYC,         32'h0,         1'b0, 1'b1, 32'hFFFF_FFFE});
        vecs.push_back('{A_CYC,         32'h0,         1'b0, 1'b1, 32'hFFFF_FFFF});
        vecs.push_back('{A_CYC,         32'h0,         1'b0, 1'b1, 32'h0000_0000});
        vecs.push_back('{A_CYC,         32'h0,         1'b0, 1'b1, 32'h0000_0001});
        vecs.push_back('{32'hFFFF_FF0C, 32'h0,         1'b0, 1'b1, 32'h0});

        applyStimulus(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        checkOutput("rst_data_out", data_out, 32'h0);
        checkOutput("rst_console_valid", 32'(console_valid), 32'h0);
        checkOutput("rst_console_data", 32'(console_data), 32'h0);
        applyStimulus(A_CYC, 32'h0, 1'b0, 1'b0, 1'b1);
        checkOutput("cycle_after_reset", data_out, 32'h0);
        applyStimulus(A_CYC, 32'h0, 1'b0, 1'b0, 1'b1);
        checkOutput("cycle_second", data_out, 32'h1);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].addr, vecs[i].din, vecs[i].w, 1'b0, 1'b1);
            if (vecs[i].chk) checkOutput($sformatf("vec%0d", i), data_out, vecs[i].exp);
        end

`ifdef MEMORY_RESPONDER_CONSOLE_EN
        for (int i = 0; i < 5; i++) applyStimulus(A_TX, 32'h41 + 32'(i), 1'b1, 1'b0, 1'b1);
        applyStimulus(A_ST, 32'h0, 1'b0, 1'b0, 1'b1);
        checkOutput("overflow_status", data_out, 32'h0000_0406);
        for (int i = 0; i < 4; i++) begin
            checkOutput("drain_order", 32'(console_data), 32'h41 + 32'(i));
            applyStimulus(A_NUL, 32'h0, 1'b0, 1'b1, 1'b1);
        end
        checkOutput("drained_valid", 32'(console_valid), 32'h0);
        applyStimulus(A_ST, 32'h0, 1'b1, 1'b0, 1'b1);
        applyStimulus(A_ST, 32'h0, 1'b0, 1'b0, 1'b1);
        checkOutput("overflow_cleared", data_out, 32'h0000_0001);

        for (int i = 1; i <= 4; i++) applyStimulus(A_TX, 32'(i), 1'b1, 1'b0, 1'b1);
        applyStimulus(A_TX, 32'h55, 1'b1, 1'b1, 1'b1);
        applyStimulus(A_ST, 32'h0, 1'b0, 1'b0, 1'b1);
        checkOutput("full_push_pop_status", data_out, 32'h0000_0402);
        for (int i = 0; i < 3; i++) applyStimulus(A_NUL, 32'h0, 1'b0, 1'b1, 1'b1);
        checkOutput("push_pop_last", 32'(console_data), 32'h55);
        applyStimulus(A_NUL, 32'h0, 1'b0, 1'b1, 1'b1);
        checkOutput("push_pop_empty", 32'(console_valid), 32'h0);

        applyStimulus(A_TX, 32'h66, 1'b1, 1'b1, 1'b1);
        checkOutput("no_bypass_valid", 32'(console_valid), 32'h1);
        checkOutput("no_bypass_data", 32'(console_data), 32'h66);
        applyStimulus(A_TX, 32'h67, 1'b1, 1'b0, 1'b1);
        applyStimulus(A_TX, 32'h68, 1'b1, 1'b0, 1'b1);
        applyStimulus(32'h10, 32'h1234_5678, 1'b1, 1'b1, 1'b0);
        checkOutput("midop_reset_valid", 32'(console_valid), 32'h0);
        applyStimulus(A_ST, 32'h0, 1'b0, 1'b0, 1'b1);
        checkOutput("midop_reset_status", data_out, 32'h0000_0001);
`else
        applyStimulus(A_TX, 32'h41, 1'b1, 1'b1, 1'b1);
        checkOutput("no_console_valid", 32'(console_valid), 32'h0);
        checkOutput("no_console_data", 32'(console_data), 32'h0);
        applyStimulus(A_ST, 32'h0, 1'b0, 1'b0, 1'b1);
        checkOutput("no_console_status", data_out, 32'h0);
        applyStimulus(32'h10, 32'h1234_5678, 1'b1, 1'b1, 1'b0);
`endif
        applyStimulus(32'h10, 32'h0, 1'b0, 1'b0, 1'b1);
        checkOutput("ram_survives_reset", data_out, 32'hDEAD_BEEF);

        for (int n = 0; n < 600; n++) begin
            sel = $urandom_range(0, 99);
            if (sel < 40)      a = 32'($urandom_range(0, 15)) * 32'd4 + 32'($urandom_range(0, 3));
            else if (sel < 48) a = 32'h0000_0FFC + 32'($urandom_range(0, 3));
            else if (sel < 63) a = A_TX;
            else if (sel < 77) a = A_ST;
            else if (sel < 87) a = A_CYC;
            else               a = $urandom;
            d  = $urandom;
            w  = (a == A_CYC) ? ($urandom_range(0, 4) == 0) : 1'($urandom_range(0, 1));
            r  = ($urandom_range(0, 3) == 0);
            rn = ($urandom_range(0, 99) != 0);
            applyStimulus(a, d, w, r, rn);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
